// File: rtl/cordic_bus_pkg.sv
// Register offsets, control/flag bit positions and reset words shared by the
// CORDIC register bank and the CORDIC controller.
package cordic_bus_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_X       = 8'h04;
    localparam logic [7:0] ADDR_Y       = 8'h08;
    localparam logic [7:0] ADDR_Z       = 8'h0C;
    localparam logic [7:0] ADDR_IRQSTAT = 8'h10;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_READY_BIT = 16;
    localparam int CTRL_ERROR_BIT = 17;

    localparam int IRQ_DONE_BIT   = 0;
    localparam int IRQ_REJECT_BIT = 1;

    localparam logic [31:0] SHADOW_RST = 32'h0000_3FF0;
    localparam logic [31:0] STATUS_RST = 32'h0001_3FF0;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_X,
        SEL_Y,
        SEL_Z,
        SEL_IRQSTAT,
        SEL_NONE
    } reg_sel_e;

    // Byte address to register select; the two low address bits are ignored.
    function automatic reg_sel_e decode_addr(input logic [7:0] addr);
        logic [7:0] word_addr;
        word_addr = {addr[7:2], 2'b00};
        case (word_addr)
            ADDR_CTRL:    decode_addr = SEL_CTRL;
            ADDR_X:       decode_addr = SEL_X;
            ADDR_Y:       decode_addr = SEL_Y;
            ADDR_Z:       decode_addr = SEL_Z;
            ADDR_IRQSTAT: decode_addr = SEL_IRQSTAT;
            default:      decode_addr = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cordic_reg_bank_if.sv
// Host bus of the CORDIC register bank: one-cycle select, acknowledge one cycle later.
interface cordic_reg_bank_if #(
    parameter int p_WIDTH  = 32,
    parameter int p_ADDR_W = 5
);
    logic                bus_sel;
    logic                bus_wr;
    logic [p_ADDR_W-1:0] bus_addr;
    logic [p_WIDTH-1:0]  bus_wdata;
    logic [p_WIDTH-1:0]  bus_rdata;
    logic                bus_ack;

    modport master (
        output bus_sel, bus_wr, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_sel, bus_wr, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/cordic_reg_bank.sv
// Host-visible register bank for the CORDIC controller: operand/config registers,
// start/stop command pulses, result/status capture and a sticky interrupt.
module cordic_reg_bank
    import cordic_bus_pkg::*;
#(
    parameter int p_WIDTH  = 32,
    parameter int p_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    cordic_reg_bank_if.slave   bus,
    output logic [31:0]        ctrl_in,
    output logic [p_WIDTH-1:0] x_in,
    output logic [p_WIDTH-1:0] y_in,
    output logic [p_WIDTH-1:0] z_in,
    input  logic [31:0]        ctrl_out,
    input  logic               ctrl_we,
    input  logic [p_WIDTH-1:0] x_res,
    input  logic [p_WIDTH-1:0] y_res,
    input  logic [p_WIDTH-1:0] z_res,
    input  logic               ctrl_irq,
    output logic               irq
);

    // shadow_q holds shadow[15:2]; status_hi_q holds status[31:16] (the only readable half)
    logic [13:0]        shadow_q, shadow_d;
    logic [15:0]        status_hi_q, status_hi_d;
    logic [p_WIDTH-1:0] x_op_q, x_op_d, y_op_q, y_op_d, z_op_q, z_op_d;
    logic [p_WIDTH-1:0] x_rs_q, x_rs_d, y_rs_q, y_rs_d, z_rs_q, z_rs_d;
    logic               busy_q, busy_d;
    logic               start_p_q, start_p_d;
    logic               stop_p_q, stop_p_d;
    logic [1:0]         irq_stat_q, irq_stat_d;
    logic               ack_q, ack_d;
    logic [p_WIDTH-1:0] rdata_q, rdata_d;

    logic [7:0] addr_b;
    reg_sel_e   sel;
    logic       wr_en, rd_en, reject;
    logic [1:0] w1c;
    logic       unused_ctrl_out;

    assign addr_b          = 8'(bus.bus_addr);
    assign unused_ctrl_out = ^ctrl_out[15:0];

    always_comb begin
        shadow_d    = shadow_q;
        status_hi_d = status_hi_q;
        x_op_d      = x_op_q;
        y_op_d      = y_op_q;
        z_op_d      = z_op_q;
        x_rs_d      = x_rs_q;
        y_rs_d      = y_rs_q;
        z_rs_d      = z_rs_q;
        busy_d      = busy_q;
        start_p_d   = 1'b0;
        stop_p_d    = 1'b0;
        ack_d       = bus.bus_sel;
        rdata_d     = '0;
        reject      = 1'b0;
        w1c         = 2'b00;
        sel         = decode_addr(addr_b);
        wr_en       = bus.bus_sel & bus.bus_wr;
        rd_en       = bus.bus_sel & ~bus.bus_wr;

        if (ctrl_we) begin
            status_hi_d = ctrl_out[31:16];
            x_rs_d      = x_res;
            y_rs_d      = y_res;
            z_rs_d      = z_res;
            if (ctrl_out[CTRL_READY_BIT]) begin
                busy_d = 1'b0;
            end
        end

        // A running computation freezes shadow and operands; STOP is the only command it accepts.
        if (wr_en) begin
            case (sel)
                SEL_CTRL: begin
                    if (busy_q) begin
                        if (bus.bus_wdata[CTRL_START_BIT]) reject = 1'b1;
                        if (bus.bus_wdata[CTRL_STOP_BIT])  stop_p_d = 1'b1;
                    end else begin
                        shadow_d[11:0] = bus.bus_wdata[13:2];
                        if (bus.bus_wdata[CTRL_START_BIT]) begin
                            start_p_d = 1'b1;
                            busy_d    = 1'b1;
                        end
                    end
                end
                SEL_X: if (busy_q) reject = 1'b1; else x_op_d = bus.bus_wdata;
                SEL_Y: if (busy_q) reject = 1'b1; else y_op_d = bus.bus_wdata;
                SEL_Z: if (busy_q) reject = 1'b1; else z_op_d = bus.bus_wdata;
                SEL_IRQSTAT: w1c = bus.bus_wdata[1:0];
                default: ;
            endcase
        end

        if (rd_en) begin
            case (sel)
                SEL_CTRL:    rdata_d = p_WIDTH'({status_hi_q, shadow_q, 2'b00});
                SEL_X:       rdata_d = x_rs_q;
                SEL_Y:       rdata_d = y_rs_q;
                SEL_Z:       rdata_d = z_rs_q;
                SEL_IRQSTAT: rdata_d = p_WIDTH'(irq_stat_q);
                default:     rdata_d = '0;
            endcase
        end

        // Set is applied after clear so a coincident event is never lost.
        irq_stat_d = irq_stat_q & ~w1c;
        if (ctrl_irq) irq_stat_d[IRQ_DONE_BIT]   = 1'b1;
        if (reject)   irq_stat_d[IRQ_REJECT_BIT] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= SHADOW_RST[15:2];
            status_hi_q <= STATUS_RST[31:16];
            x_op_q      <= '0;
            y_op_q      <= '0;
            z_op_q      <= '0;
            x_rs_q      <= '0;
            y_rs_q      <= '0;
            z_rs_q      <= '0;
            busy_q      <= 1'b0;
            start_p_q   <= 1'b0;
            stop_p_q    <= 1'b0;
            irq_stat_q  <= 2'b00;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            shadow_q    <= shadow_d;
            status_hi_q <= status_hi_d;
            x_op_q      <= x_op_d;
            y_op_q      <= y_op_d;
            z_op_q      <= z_op_d;
            x_rs_q      <= x_rs_d;
            y_rs_q      <= y_rs_d;
            z_rs_q      <= z_rs_d;
            busy_q      <= busy_d;
            start_p_q   <= start_p_d;
            stop_p_q    <= stop_p_d;
            irq_stat_q  <= irq_stat_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ctrl_in       = {16'h0000, shadow_q, stop_p_q, start_p_q};
    assign x_in          = x_op_q;
    assign y_in          = y_op_q;
    assign z_in          = z_op_q;
    assign irq           = |irq_stat_q;
    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_cordic_reg_bank.sv
// Scenario bench for cordic_reg_bank: read expectations queued at issue time,
// checked together with ack timing by a monitor on the falling edge.
module tb_cordic_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl_in, x_in, y_in, z_in;
    logic [31:0] ctrl_out = '0;
    logic        ctrl_we  = 1'b0;
    logic [31:0] x_res = '0, y_res = '0, z_res = '0;
    logic        ctrl_irq = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        sel_seen = 1'b0;
    logic        rd_seen  = 1'b0;
    bit          mon_en   = 1'b0;

    localparam logic [4:0] A_CTRL = 5'h00, A_X = 5'h04, A_Y = 5'h08, A_Z = 5'h0C;
    localparam logic [4:0] A_IRQ  = 5'h10, A_UNM = 5'h14, A_UNM2 = 5'h1C;

    always #5 clk = ~clk;

    cordic_reg_bank_if #(.p_WIDTH(32), .p_ADDR_W(5)) bus ();

    cordic_reg_bank #(.p_WIDTH(32), .p_ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .ctrl_in  (ctrl_in),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .ctrl_out (ctrl_out),
        .ctrl_we  (ctrl_we),
        .x_res    (x_res),
        .y_res    (y_res),
        .z_res    (z_res),
        .ctrl_irq (ctrl_irq),
        .irq      (irq)
    );

    always @(posedge clk) begin
        sel_seen <= bus.bus_sel && !rst;
        rd_seen  <= bus.bus_sel && !bus.bus_wr && !rst;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] exp;
            checks++;
            if (bus.bus_ack !== sel_seen) begin
                errors++;
                $display("FAIL ack_timing t=%0t got %b want %b", $time, bus.bus_ack, sel_seen);
            end
            if (sel_seen && rd_seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdata_unexpected t=%0t got %h want no read", $time, bus.bus_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.bus_rdata !== exp) begin
                        errors++;
                        $display("FAIL rdata t=%0t got %h want %h", $time, bus.bus_rdata, exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.bus_sel   = 1'b1;
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        @(negedge clk);
        bus.bus_sel = 1'b0;
        bus.bus_wr  = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.bus_sel  = 1'b1;
        bus.bus_wr   = 1'b0;
        bus.bus_addr = a;
        @(negedge clk);
        bus.bus_sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.bus_sel = 1'b0; bus.bus_wr = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ctrl_in !== 32'h0000_3FF0) begin errors++; $display("FAIL reset_ctrl_in got %h want 00003ff0", ctrl_in); end
        checks++;
        if (x_in !== 0 || y_in !== 0 || z_in !== 0) begin errors++; $display("FAIL reset_operands got %h %h %h want 0", x_in, y_in, z_in); end
        checks++;
        if (irq !== 1'b0 || bus.bus_ack !== 1'b0 || bus.bus_rdata !== 0) begin
            errors++; $display("FAIL reset_outputs got irq=%b ack=%b rdata=%h want 0", irq, bus.bus_ack, bus.bus_rdata);
        end
        mon_en = 1'b1;
        bus_read(A_CTRL, 32'h0001_3FF0);
        bus_read(A_IRQ,  32'h0);
        bus_read(A_X,    32'h0);
        bus_read(A_UNM,  32'h0);
    endtask

    task automatic test_start();
        bus_write(A_X, 32'h2000_0000);
        bus_write(A_Y, 32'h0);
        bus_write(A_Z, 32'h1000_0000);
        bus_write(A_CTRL, 32'h0000_1F0D);
        checks++;
        if (ctrl_in !== 32'h0000_1F0D) begin errors++; $display("FAIL start_pulse got %h want 00001f0d", ctrl_in); end
        checks++;
        if (x_in !== 32'h2000_0000 || y_in !== 0 || z_in !== 32'h1000_0000) begin
            errors++; $display("FAIL operands got %h %h %h want 20000000 0 10000000", x_in, y_in, z_in);
        end
        @(negedge clk);
        checks++;
        if (ctrl_in !== 32'h0000_1F0C) begin errors++; $display("FAIL start_pulse_end got %h want 00001f0c", ctrl_in); end
        bus_read(A_CTRL, 32'h0001_1F0C);
    endtask

    task automatic test_busy_reject();
        bus_write(A_X, 32'h5);
        bus_write(A_CTRL, 32'h0000_0001);
        checks++;
        if (ctrl_in !== 32'h0000_1F0C) begin errors++; $display("FAIL busy_start got %h want 00001f0c", ctrl_in); end
        checks++;
        if (x_in !== 32'h2000_0000) begin errors++; $display("FAIL busy_operand got %h want 20000000", x_in); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reject_irq got %b want 1", irq); end
        bus_read(A_IRQ, 32'h2);
    endtask

    task automatic test_stop();
        int pulses = 0;
        bus_write(A_CTRL, 32'h0000_0002);
        for (int i = 0; i < 4; i++) begin
            if (ctrl_in[1] === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL stop_pulse_count got %0d want 1", pulses); end
        checks++;
        if (ctrl_in !== 32'h0000_1F0C) begin errors++; $display("FAIL stop_shadow got %h want 00001f0c", ctrl_in); end
    endtask

    task automatic test_capture();
        ctrl_we = 1'b1; ctrl_out = 32'h0000_ABCD;
        x_res = 32'h0BAD_0001; y_res = 32'h0; z_res = 32'h0;
        @(negedge clk);
        ctrl_we = 1'b0;
        bus_write(A_X, 32'h7);
        checks++;
        if (x_in !== 32'h2000_0000) begin errors++; $display("FAIL not_ready_busy got %h want 20000000", x_in); end
        bus_read(A_CTRL, 32'h0000_1F0C);
        bus_read(A_X, 32'h0BAD_0001);

        ctrl_we = 1'b1; ctrl_irq = 1'b1; ctrl_out = 32'h0001_0005;
        x_res = 32'h1234_5678; y_res = 32'hAAAA_5555; z_res = 32'h0BAD_F00D;
        @(negedge clk);
        ctrl_we = 1'b0; ctrl_irq = 1'b0; ctrl_out = 32'h0;
        bus_read(A_X, 32'h1234_5678);
        bus_read(A_Y, 32'hAAAA_5555);
        bus_read(A_Z, 32'h0BAD_F00D);
        bus_read(A_CTRL, 32'h0001_1F0C);
        bus_read(A_IRQ, 32'h3);
        bus_write(A_IRQ, 32'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_partial got %b want 1", irq); end
        bus_write(A_IRQ, 32'h2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b want 0", irq); end
        bus_read(A_IRQ, 32'h0);
    endtask

    task automatic test_stop_idle();
        int pulses = 0;
        bus_write(A_CTRL, 32'h0000_1F0E);
        for (int i = 0; i < 3; i++) begin
            if (ctrl_in[1:0] !== 2'b00) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0 || ctrl_in !== 32'h0000_1F0C) begin
            errors++; $display("FAIL stop_idle got pulses=%0d ctrl_in=%h want 0 00001f0c", pulses, ctrl_in);
        end
        bus_read(A_IRQ, 32'h0);
    endtask

    task automatic test_irq_coincide();
        ctrl_irq = 1'b1;
        @(negedge clk);
        ctrl_irq = 1'b1;
        bus_write(A_IRQ, 32'h1);
        ctrl_irq = 1'b0;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b want 1", irq); end
        bus_read(A_IRQ, 32'h1);
        bus_write(A_IRQ, 32'h1);
        bus_read(A_IRQ, 32'h0);
    endtask

    task automatic test_back_to_back();
        bus_write(A_X, 32'h11);
        bus_write(A_Y, 32'h22);
        bus_write(A_Z, 32'h33);
        checks++;
        if (x_in !== 32'h11 || y_in !== 32'h22 || z_in !== 32'h33) begin
            errors++; $display("FAIL b2b_operands got %h %h %h want 11 22 33", x_in, y_in, z_in);
        end
        bus_read(A_X, 32'h1234_5678);
        bus_read(A_Y, 32'hAAAA_5555);
        bus_read(A_UNM2, 32'h0);
        bus_read(A_CTRL, 32'h0001_1F0C);
        bus_write(A_CTRL, 32'h0000_0003);
        checks++;
        if (ctrl_in !== 32'h0000_0001) begin errors++; $display("FAIL start_and_stop got %h want 00000001", ctrl_in); end
        @(negedge clk);
        checks++;
        if (ctrl_in !== 32'h0000_0000) begin errors++; $display("FAIL start_and_stop_end got %h want 00000000", ctrl_in); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        bus_write(A_X, 32'h99);
        rst = 1'b0;
        checks++;
        if (ctrl_in !== 32'h0000_3FF0 || x_in !== 0 || y_in !== 0 || z_in !== 0 || irq !== 1'b0) begin
            errors++; $display("FAIL mid_reset got ctrl_in=%h x=%h y=%h z=%h irq=%b want 3ff0 0 0 0 0", ctrl_in, x_in, y_in, z_in, irq);
        end
        bus_read(A_CTRL, 32'h0001_3FF0);
        bus_read(A_X, 32'h0);
        bus_write(A_CTRL, 32'h0000_3FF1);
        checks++;
        if (ctrl_in !== 32'h0000_3FF1) begin errors++; $display("FAIL mid_reset_idle got %h want 00003ff1", ctrl_in); end
        bus_read(A_IRQ, 32'h0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_start();
        test_busy_reject();
        test_stop();
        test_capture();
        test_stop_idle();
        test_irq_coincide();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pending_reads got %0d want 0", exp_q.size()); end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
